mem_lsu: RTL

Load/store unit directly upstream of the MEM stage. It takes the EX/MEM memory operation and runs a req/ack transaction on the data-RAM port. It produces the byte-lane-aligned, sign/zero-extended load data that MEM consumes as ram_data_i. While a RAM access is outstanding it stalls the pipeline, and it bounds every access with a timeout.

---
 rtl/mem_lsu_pkg.sv | 26 ++
 rtl/mem_lsu_align.sv | 88 ++++++++
 rtl/mem_lsu.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared opcodes, funct3 codes and FSM encoding for the load/store unit.
// Imported by lsu_align and mem_lsu.
package mem_lsu_pkg;

  localparam logic [6:0] OP_I_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_mem_op(
    input logic [6:0] op
  );
    return (op == OP_I_LOAD) || (op == OP_S);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane logic: enables, store replication, legality, load extension.
// Ports: request side (funct3/addr_lo/store_data) and load side (ld_*).
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        legal,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic sz_b;
  logic sz_h;
  logic sz_w;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // funct3[1:0] carries the size for both signed and unsigned forms
  assign sz_b = (funct3[1:0] == 2'b00);
  assign sz_h = (funct3[1:0] == 2'b01);
  assign sz_w = (funct3[1:0] == 2'b10);

  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    unique case (1'b1)
      sz_b: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      sz_h: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      sz_w: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      default: begin
        be    = 4'b0000;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    legal = 1'b0;
    unique case (funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = ~addr_lo[0];
      F3_W:    legal = (addr_lo == 2'b00);
      F3_BU:   legal = ~is_store;
      F3_HU:   legal = ~is_store & ~addr_lo[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    unique case (ld_addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
  end

  assign ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = 32'h0;
    unique case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data = rdata;
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit ahead of MEM: req/ack RAM transaction with timeout.
// Ports: EX/MEM op in, RAM req/ack port, load data + done/stall/err out.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [6:0]  aluop_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        ram_req,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [31:0] ram_rdata,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        err_o
);

  lsu_state_e state;
  lsu_state_e state_n;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;

  logic        is_store;
  logic        mem_op;
  logic        legal;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ld_data;

  logic accept;
  logic ack_ok;
  logic tmo;

  assign is_store = (aluop_i == OP_S);
  assign mem_op   = valid_i & is_mem_op(aluop_i);

  lsu_align u_align (
    .funct3     (funct3_i),
    .addr_lo    (addr_i[1:0]),
    .is_store   (is_store),
    .store_data (store_data_i),
    .be         (be),
    .wdata      (wdata),
    .legal      (legal),
    .ld_funct3  (f3_q),
    .ld_addr_lo (lo_q),
    .rdata      (ram_rdata),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    ack_ok     = 1'b0;
    tmo        = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    unique case (state)
      LSU_IDLE: begin
        if (mem_op) begin
          if (legal) begin
            accept  = 1'b1;
            stall_o = 1'b1;
            state_n = LSU_BUSY;
          end else begin
            misalign_o = 1'b1;
          end
        end
      end
      LSU_BUSY: begin
        stall_o = 1'b1;
        // ack wins over a coincident timeout
        if (ram_ack) begin
          ack_ok  = 1'b1;
          state_n = LSU_DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_n = LSU_DONE;
        end
      end
      LSU_DONE: begin
        // EX/MEM still holds this op; never re-accept here
        state_n = LSU_IDLE;
      end
      default: begin
        state_n = LSU_IDLE;
      end
    endcase
    if (rst) begin
      stall_o    = 1'b0;
      misalign_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LSU_IDLE;
      cnt         <= '0;
      f3_q        <= 3'b000;
      lo_q        <= 2'b00;
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_be      <= 4'b0000;
      ram_addr    <= 32'h0;
      ram_wdata   <= 32'h0;
      load_data_o <= 32'h0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state  <= state_n;
      done_o <= ack_ok;
      err_o  <= tmo;
      if (accept) begin
        ram_req   <= 1'b1;
        ram_we    <= is_store;
        ram_be    <= be;
        ram_addr  <= {addr_i[31:2], 2'b00};
        ram_wdata <= wdata;
        f3_q      <= funct3_i;
        lo_q      <= addr_i[1:0];
        cnt       <= '0;
      end
      if (state == LSU_BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (ack_ok) begin
        ram_req <= 1'b0;
        if (!ram_we) begin
          load_data_o <= ld_data;
        end
      end
      if (tmo) begin
        ram_req     <= 1'b0;
        load_data_o <= 32'h0;
      end
    end
  end

endmodule
